// File: rtl/mem_lsu_pkg.sv
// Shared widths, access-size and FSM encodings for the memory-access stage.
// Also holds the size-dependent byte-mask and alignment helpers.
package mem_lsu_pkg;

  localparam int DATA_BUS      = 64;
  localparam int REG_BUS       = 64;
  localparam int REG_INDEX_BUS = 5;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  return 8'h01;
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
    case (size)
      SIZE_H:  return offset[0];
      SIZE_W:  return |offset[1:0];
      SIZE_D:  return |offset;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane alignment: extracts and extends load data from a doubleword,
// and shifts store data / byte enables into their lanes.
module mem_align
  import mem_lsu_pkg::*;
(
  input  logic [2:0]          offset,
  input  logic [1:0]          size,
  input  logic                is_unsigned,
  input  logic [DATA_BUS-1:0] rdata,
  input  logic [DATA_BUS-1:0] wdata,
  output logic [DATA_BUS-1:0] load_data,
  output logic [DATA_BUS-1:0] store_data,
  output logic [7:0]          store_mask
);

  logic [5:0]          shamt;
  logic [DATA_BUS-1:0] lane;
  logic [DATA_BUS-1:0] wtrunc;

  assign shamt = {offset, 3'b000};
  assign lane  = rdata >> shamt;

  always_comb begin
    load_data = lane;
    wtrunc    = wdata;
    case (size)
      SIZE_B: begin
        load_data = is_unsigned ? {56'b0, lane[7:0]} : {{56{lane[7]}}, lane[7:0]};
        wtrunc    = {56'b0, wdata[7:0]};
      end
      SIZE_H: begin
        load_data = is_unsigned ? {48'b0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
        wtrunc    = {48'b0, wdata[15:0]};
      end
      SIZE_W: begin
        load_data = is_unsigned ? {32'b0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
        wtrunc    = {32'b0, wdata[31:0]};
      end
      default: ;
    endcase
  end

  assign store_data = wtrunc << shamt;
  assign store_mask = size_mask(size) << offset;

endmodule

// File: rtl/mem_lsu.sv
// Memory-access stage: passes ALU results through, runs one data-bus
// request/response per load or store and stalls upstream while it is in flight.
module mem_lsu
  import mem_lsu_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lsu_inst_valid_i,
  input  logic [REG_INDEX_BUS-1:0] lsu_rd_index_i,
  input  logic                     lsu_rd_en_i,
  input  logic [REG_BUS-1:0]       lsu_alu_result_i,
  input  logic                     lsu_mem_rd_i,
  input  logic                     lsu_mem_wr_i,
  input  logic [1:0]               lsu_mem_size_i,
  input  logic                     lsu_mem_unsigned_i,
  input  logic [DATA_BUS-1:0]      lsu_mem_addr_i,
  input  logic [DATA_BUS-1:0]      lsu_mem_wdata_i,
  input  logic                     lsu_flush_i,
  output logic                     lsu_stall_o,
  output logic                     lsu_misalign_o,
  output logic                     dbus_req_valid_o,
  input  logic                     dbus_req_ready_i,
  output logic                     dbus_req_wen_o,
  output logic [DATA_BUS-1:0]      dbus_req_addr_o,
  output logic [DATA_BUS-1:0]      dbus_req_wdata_o,
  output logic [7:0]               dbus_req_wmask_o,
  input  logic                     dbus_rsp_valid_i,
  input  logic [DATA_BUS-1:0]      dbus_rsp_rdata_i,
  output logic                     mem2wb_inst_valid_o,
  output logic [REG_INDEX_BUS-1:0] mem2wb_rd_index_o,
  output logic                     mem2wb_rd_en_o,
  output logic [REG_BUS-1:0]       mem2wb_rd_data_o
);

  lsu_state_e state, state_next;
  logic       drop, drop_next;
  logic       latch_en;
  logic       mem_op;
  logic       misalign;

  logic [REG_INDEX_BUS-1:0] rd_index_q;
  logic                     rd_en_q;
  logic [1:0]               size_q;
  logic                     unsigned_q;
  logic                     wen_q;
  logic [2:0]               offset_q;
  logic [DATA_BUS-4:0]      line_q;
  logic [7:0]               wmask_q;
  logic [DATA_BUS-1:0]      wdata_q;

  logic [DATA_BUS-1:0] load_data;
  logic [DATA_BUS-1:0] store_data;
  logic [7:0]          store_mask;
  logic [DATA_BUS-1:0] load_path_wdata_unused;
  logic [7:0]          load_path_wmask_unused;
  logic [DATA_BUS-1:0] store_path_rdata_unused;

  assign mem_op   = lsu_inst_valid_i & (lsu_mem_rd_i | lsu_mem_wr_i);
  assign misalign = misaligned(lsu_mem_size_i, lsu_mem_addr_i[2:0]);

  mem_align u_load_align (
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .rdata       (dbus_rsp_rdata_i),
    .wdata       ('0),
    .load_data   (load_data),
    .store_data  (load_path_wdata_unused),
    .store_mask  (load_path_wmask_unused)
  );

  mem_align u_store_align (
    .offset      (lsu_mem_addr_i[2:0]),
    .size        (lsu_mem_size_i),
    .is_unsigned (1'b0),
    .rdata       ('0),
    .wdata       (lsu_mem_wdata_i),
    .load_data   (store_path_rdata_unused),
    .store_data  (store_data),
    .store_mask  (store_mask)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      drop  <= 1'b0;
    end else begin
      state <= state_next;
      drop  <= drop_next;
    end
  end

  // Transaction fields captured at issue; held stable on the bus until handshake.
  always_ff @(posedge clk) begin
    if (latch_en) begin
      rd_index_q <= lsu_rd_index_i;
      rd_en_q    <= lsu_rd_en_i;
      size_q     <= lsu_mem_size_i;
      unsigned_q <= lsu_mem_unsigned_i;
      wen_q      <= lsu_mem_wr_i;
      offset_q   <= lsu_mem_addr_i[2:0];
      line_q     <= lsu_mem_addr_i[DATA_BUS-1:3];
      wmask_q    <= store_mask;
      wdata_q    <= store_data;
    end
  end

  always_comb begin
    state_next          = state;
    drop_next           = drop;
    latch_en            = 1'b0;
    lsu_stall_o         = 1'b0;
    lsu_misalign_o      = 1'b0;
    dbus_req_valid_o    = 1'b0;
    dbus_req_wen_o      = 1'b0;
    dbus_req_addr_o     = '0;
    dbus_req_wdata_o    = '0;
    dbus_req_wmask_o    = '0;
    mem2wb_inst_valid_o = 1'b0;
    mem2wb_rd_index_o   = '0;
    mem2wb_rd_en_o      = 1'b0;
    mem2wb_rd_data_o    = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (mem_op && !lsu_flush_i) begin
            if (misalign) begin
              lsu_misalign_o      = 1'b1;
              mem2wb_inst_valid_o = 1'b1;
              mem2wb_rd_index_o   = lsu_rd_index_i;
            end else begin
              latch_en    = 1'b1;
              lsu_stall_o = 1'b1;
              state_next  = ST_REQ;
            end
          end else begin
            mem2wb_inst_valid_o = lsu_inst_valid_i & ~lsu_flush_i;
            mem2wb_rd_index_o   = lsu_rd_index_i;
            mem2wb_rd_en_o      = lsu_rd_en_i;
            mem2wb_rd_data_o    = lsu_alu_result_i;
          end
        end
        ST_REQ: begin
          lsu_stall_o      = 1'b1;
          dbus_req_valid_o = 1'b1;
          dbus_req_wen_o   = wen_q;
          dbus_req_addr_o  = {line_q, 3'b000};
          dbus_req_wdata_o = wdata_q;
          dbus_req_wmask_o = wmask_q;
          // A flush in the handshake cycle cannot cancel the request, only its retirement.
          if (dbus_req_ready_i) begin
            state_next = ST_RESP;
            drop_next  = lsu_flush_i;
          end else if (lsu_flush_i) begin
            state_next = ST_IDLE;
          end
        end
        ST_RESP: begin
          if (lsu_flush_i) drop_next = 1'b1;
          if (dbus_rsp_valid_i) begin
            state_next          = ST_IDLE;
            drop_next           = 1'b0;
            mem2wb_inst_valid_o = ~(drop | lsu_flush_i);
            mem2wb_rd_index_o   = rd_index_q;
            mem2wb_rd_en_o      = rd_en_q & ~wen_q;
            mem2wb_rd_data_o    = wen_q ? '0 : load_data;
          end else begin
            lsu_stall_o = 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed scenarios followed by randomized transactions
// checked against a byte-level reference model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_inst_valid_i;
  logic [4:0]  lsu_rd_index_i;
  logic        lsu_rd_en_i;
  logic [63:0] lsu_alu_result_i;
  logic        lsu_mem_rd_i;
  logic        lsu_mem_wr_i;
  logic [1:0]  lsu_mem_size_i;
  logic        lsu_mem_unsigned_i;
  logic [63:0] lsu_mem_addr_i;
  logic [63:0] lsu_mem_wdata_i;
  logic        lsu_flush_i;
  logic        lsu_stall_o;
  logic        lsu_misalign_o;
  logic        dbus_req_valid_o;
  logic        dbus_req_ready_i;
  logic        dbus_req_wen_o;
  logic [63:0] dbus_req_addr_o;
  logic [63:0] dbus_req_wdata_o;
  logic [7:0]  dbus_req_wmask_o;
  logic        dbus_rsp_valid_i;
  logic [63:0] dbus_rsp_rdata_i;
  logic        mem2wb_inst_valid_o;
  logic [4:0]  mem2wb_rd_index_o;
  logic        mem2wb_rd_en_o;
  logic [63:0] mem2wb_rd_data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk                 (clk),
    .rst                 (rst),
    .lsu_inst_valid_i    (lsu_inst_valid_i),
    .lsu_rd_index_i      (lsu_rd_index_i),
    .lsu_rd_en_i         (lsu_rd_en_i),
    .lsu_alu_result_i    (lsu_alu_result_i),
    .lsu_mem_rd_i        (lsu_mem_rd_i),
    .lsu_mem_wr_i        (lsu_mem_wr_i),
    .lsu_mem_size_i      (lsu_mem_size_i),
    .lsu_mem_unsigned_i  (lsu_mem_unsigned_i),
    .lsu_mem_addr_i      (lsu_mem_addr_i),
    .lsu_mem_wdata_i     (lsu_mem_wdata_i),
    .lsu_flush_i         (lsu_flush_i),
    .lsu_stall_o         (lsu_stall_o),
    .lsu_misalign_o      (lsu_misalign_o),
    .dbus_req_valid_o    (dbus_req_valid_o),
    .dbus_req_ready_i    (dbus_req_ready_i),
    .dbus_req_wen_o      (dbus_req_wen_o),
    .dbus_req_addr_o     (dbus_req_addr_o),
    .dbus_req_wdata_o    (dbus_req_wdata_o),
    .dbus_req_wmask_o    (dbus_req_wmask_o),
    .dbus_rsp_valid_i    (dbus_rsp_valid_i),
    .dbus_rsp_rdata_i    (dbus_rsp_rdata_i),
    .mem2wb_inst_valid_o (mem2wb_inst_valid_o),
    .mem2wb_rd_index_o   (mem2wb_rd_index_o),
    .mem2wb_rd_en_o      (mem2wb_rd_en_o),
    .mem2wb_rd_data_o    (mem2wb_rd_data_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_idle();
    lsu_inst_valid_i   = 1'b0;
    lsu_rd_index_i     = '0;
    lsu_rd_en_i        = 1'b0;
    lsu_alu_result_i   = '0;
    lsu_mem_rd_i       = 1'b0;
    lsu_mem_wr_i       = 1'b0;
    lsu_mem_size_i     = '0;
    lsu_mem_unsigned_i = 1'b0;
    lsu_mem_addr_i     = '0;
    lsu_mem_wdata_i    = '0;
    lsu_flush_i        = 1'b0;
    dbus_req_ready_i   = 1'b0;
    dbus_rsp_valid_i   = 1'b0;
    dbus_rsp_rdata_i   = '0;
  endtask

  task automatic issue(input bit st, input bit [1:0] sz, input bit uns, input logic [63:0] addr,
                       input logic [63:0] wd, input bit rden, input logic [4:0] idx);
    lsu_inst_valid_i   = 1'b1;
    lsu_mem_rd_i       = !st;
    lsu_mem_wr_i       = st;
    lsu_mem_size_i     = sz;
    lsu_mem_unsigned_i = uns;
    lsu_mem_addr_i     = addr;
    lsu_mem_wdata_i    = wd;
    lsu_rd_en_i        = rden;
    lsu_rd_index_i     = idx;
    lsu_alu_result_i   = 64'h5555_aaaa_5555_aaaa;
  endtask

  // Reference model: byte-by-byte view of the access.
  function automatic bit ref_misaligned(input logic [1:0] sz, input logic [63:0] addr);
    logic [63:0] n;
    n = 64'd1 << sz;
    return (addr % n) != 64'd0;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int off, input int sz, input bit uns);
    logic [63:0] r;
    int n;
    r = '0;
    n = 1 << sz;
    for (int i = 0; i < 8; i++) begin
      if (i < n) r[i*8 +: 8] = rdata[((off + i) % 8)*8 +: 8];
      else if (!uns && rdata[((off + n - 1) % 8)*8 + 7]) r[i*8 +: 8] = 8'hff;
    end
    return r;
  endfunction

  function automatic logic [7:0] ref_wmask(input int off, input int sz);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < (1 << sz); i++) m[(off + i) % 8] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] wd, input int off, input int sz);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < (1 << sz); i++) o[((off + i) % 8)*8 +: 8] = wd[i*8 +: 8];
    return o;
  endfunction

  task automatic mem_txn(input bit st, input bit [1:0] sz, input bit uns, input logic [63:0] addr,
                         input logic [63:0] wd, input logic [63:0] rdat, input bit rden,
                         input logic [4:0] idx, input int rdly, input int sdly, input bit fl);
    int off;
    off = int'(addr[2:0]);
    issue(st, sz, uns, addr, wd, rden, idx);
    settle();
    if (ref_misaligned(sz, addr)) begin
      chk("mis_pulse", lsu_misalign_o, 1);
      chk("mis_req_valid", dbus_req_valid_o, 0);
      chk("mis_retire", mem2wb_inst_valid_o, 1);
      chk("mis_rd_en", mem2wb_rd_en_o, 0);
      chk("mis_rd_data", mem2wb_rd_data_o, 0);
      chk("mis_stall", lsu_stall_o, 0);
      cyc();
      set_idle();
      return;
    end
    chk("issue_stall", lsu_stall_o, 1);
    chk("issue_valid", mem2wb_inst_valid_o, 0);
    chk("issue_req_valid", dbus_req_valid_o, 0);
    cyc();
    for (int r = 0; r <= rdly; r++) begin
      dbus_req_ready_i = (r == rdly);
      settle();
      chk("req_valid", dbus_req_valid_o, 1);
      chk("req_addr", dbus_req_addr_o, {addr[63:3], 3'b000});
      chk("req_wen", dbus_req_wen_o, st);
      chk("req_stall", lsu_stall_o, 1);
      chk("req_no_retire", mem2wb_inst_valid_o, 0);
      if (st) begin
        chk("req_wmask", dbus_req_wmask_o, ref_wmask(off, sz));
        chk("req_wdata", dbus_req_wdata_o, ref_wdata(wd, off, sz));
      end
      cyc();
    end
    dbus_req_ready_i = 1'b0;
    for (int s = 0; s <= sdly; s++) begin
      dbus_rsp_valid_i = (s == sdly);
      dbus_rsp_rdata_i = rdat;
      lsu_flush_i      = fl && (s == 0);
      settle();
      if (s < sdly) begin
        chk("resp_wait_stall", lsu_stall_o, 1);
        chk("resp_wait_valid", mem2wb_inst_valid_o, 0);
        chk("resp_wait_req", dbus_req_valid_o, 0);
      end else begin
        chk("resp_stall", lsu_stall_o, 0);
        chk("resp_valid", mem2wb_inst_valid_o, !fl);
        if (!fl) begin
          chk("resp_rd_en", mem2wb_rd_en_o, st ? 1'b0 : rden);
          chk("resp_rd_index", mem2wb_rd_index_o, idx);
          if (!st) chk("resp_rd_data", mem2wb_rd_data_o, ref_load(rdat, off, sz, uns));
        end
      end
      cyc();
    end
    set_idle();
  endtask

  initial begin
    int kind;
    bit [1:0] sz;
    logic [63:0] addr;
    bit fl;

    // reset with an instruction presented: outputs must still be 0
    rst = 1'b1;
    set_idle();
    lsu_inst_valid_i = 1'b1;
    lsu_rd_en_i      = 1'b1;
    lsu_alu_result_i = 64'hdead;
    cyc();
    cyc();
    chk("rst_valid", mem2wb_inst_valid_o, 0);
    chk("rst_rd_data", mem2wb_rd_data_o, 0);
    chk("rst_stall", lsu_stall_o, 0);
    chk("rst_req_valid", dbus_req_valid_o, 0);
    rst = 1'b0;
    set_idle();

    // ADD passthrough
    lsu_inst_valid_i = 1'b1;
    lsu_rd_en_i      = 1'b1;
    lsu_rd_index_i   = 5'd5;
    lsu_alu_result_i = 64'h1234;
    settle();
    chk("add_valid", mem2wb_inst_valid_o, 1);
    chk("add_rd_data", mem2wb_rd_data_o, 64'h1234);
    chk("add_rd_index", mem2wb_rd_index_o, 5);
    chk("add_stall", lsu_stall_o, 0);
    cyc();
    set_idle();

    // LB signed, ready and rsp_valid immediate
    issue(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 1'b1, 5'd7);
    dbus_req_ready_i = 1'b1;
    settle();
    chk("lb_c0_stall", lsu_stall_o, 1);
    chk("lb_c0_valid", mem2wb_inst_valid_o, 0);
    cyc();
    dbus_rsp_valid_i = 1'b1;
    dbus_rsp_rdata_i = 64'h0000_0000_8000_0000;
    settle();
    chk("lb_req_valid", dbus_req_valid_o, 1);
    chk("lb_req_addr", dbus_req_addr_o, 64'h8000_0000);
    chk("lb_req_wen", dbus_req_wen_o, 0);
    chk("lb_c1_stall", lsu_stall_o, 1);
    chk("lb_c1_valid", mem2wb_inst_valid_o, 0);
    cyc();
    settle();
    chk("lb_c2_stall", lsu_stall_o, 0);
    chk("lb_c2_valid", mem2wb_inst_valid_o, 1);
    chk("lb_rd_data", mem2wb_rd_data_o, 64'hffff_ffff_ffff_ff80);
    chk("lb_rd_en", mem2wb_rd_en_o, 1);
    cyc();
    set_idle();
    settle();
    chk("lb_after_req", dbus_req_valid_o, 0);

    // SH with ready held low for 4 cycles
    issue(1'b1, 2'd1, 1'b0, 64'h1006, 64'habcd, 1'b1, 5'd3);
    settle();
    cyc();
    for (int k = 0; k < 5; k++) begin
      dbus_req_ready_i = (k == 4);
      settle();
      chk("sh_req_valid", dbus_req_valid_o, 1);
      chk("sh_wmask", dbus_req_wmask_o, 8'hc0);
      chk("sh_wdata", dbus_req_wdata_o, 64'habcd_0000_0000_0000);
      chk("sh_addr", dbus_req_addr_o, 64'h1000);
      chk("sh_wen", dbus_req_wen_o, 1);
      cyc();
    end
    dbus_req_ready_i = 1'b0;
    dbus_rsp_valid_i = 1'b1;
    settle();
    chk("sh_retire", mem2wb_inst_valid_o, 1);
    chk("sh_rd_en", mem2wb_rd_en_o, 0);
    chk("sh_stall", lsu_stall_o, 0);
    cyc();
    set_idle();

    // LW misaligned
    issue(1'b0, 2'd2, 1'b0, 64'h1002, 64'h0, 1'b1, 5'd4);
    settle();
    chk("lw_mis_pulse", lsu_misalign_o, 1);
    chk("lw_mis_req", dbus_req_valid_o, 0);
    chk("lw_mis_retire", mem2wb_inst_valid_o, 1);
    chk("lw_mis_rd_en", mem2wb_rd_en_o, 0);
    chk("lw_mis_stall", lsu_stall_o, 0);
    cyc();
    set_idle();
    settle();
    chk("lw_mis_pulse_end", lsu_misalign_o, 0);

    // flush in REQ with ready low
    issue(1'b0, 2'd3, 1'b0, 64'h2000, 64'h0, 1'b1, 5'd9);
    settle();
    cyc();
    settle();
    chk("flreq_req_valid", dbus_req_valid_o, 1);
    lsu_flush_i = 1'b1;
    settle();
    chk("flreq_valid", mem2wb_inst_valid_o, 0);
    cyc();
    set_idle();
    settle();
    chk("flreq_idle_req", dbus_req_valid_o, 0);
    chk("flreq_idle_stall", lsu_stall_o, 0);
    chk("flreq_idle_valid", mem2wb_inst_valid_o, 0);

    // flush in RESP: response still awaited, nothing retires
    mem_txn(1'b0, 2'd3, 1'b0, 64'h2008, 64'h0, 64'h1111, 1'b1, 5'd6, 0, 2, 1'b1);

    // LWU
    mem_txn(1'b0, 2'd2, 1'b1, 64'h1004, 64'h0, 64'h8765_4321_0000_0000, 1'b1, 5'd8, 0, 0, 1'b0);

    // reset while in RESP
    issue(1'b0, 2'd2, 1'b1, 64'h1004, 64'h0, 1'b1, 5'd8);
    dbus_req_ready_i = 1'b1;
    cyc();
    cyc();
    settle();
    chk("rstresp_stall", lsu_stall_o, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_idle();
    settle();
    chk("rstresp_req", dbus_req_valid_o, 0);
    chk("rstresp_stall_idle", lsu_stall_o, 0);
    chk("rstresp_valid", mem2wb_inst_valid_o, 0);
    chk("rstresp_data", mem2wb_rd_data_o, 0);
    dbus_rsp_valid_i = 1'b1;
    settle();
    chk("stray_rsp_valid", mem2wb_inst_valid_o, 0);
    cyc();
    set_idle();

    // randomized mix
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        lsu_inst_valid_i = 1'($urandom_range(0, 1));
        lsu_rd_index_i   = 5'($urandom);
        lsu_rd_en_i      = 1'($urandom_range(0, 1));
        lsu_alu_result_i = {$urandom, $urandom};
        lsu_flush_i      = ($urandom_range(0, 3) == 0);
        settle();
        chk("pt_valid", mem2wb_inst_valid_o, lsu_inst_valid_i & ~lsu_flush_i);
        chk("pt_rd_data", mem2wb_rd_data_o, lsu_alu_result_i);
        chk("pt_rd_index", mem2wb_rd_index_o, lsu_rd_index_i);
        chk("pt_rd_en", mem2wb_rd_en_o, lsu_rd_en_i);
        chk("pt_stall", lsu_stall_o, 0);
        chk("pt_req", dbus_req_valid_o, 0);
        cyc();
        set_idle();
      end else begin
        sz   = 2'($urandom_range(0, 3));
        addr = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
        fl   = ($urandom_range(0, 4) == 0);
        mem_txn(kind == 2, sz, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom},
                {$urandom, $urandom}, 1'($urandom_range(0, 1)), 5'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), fl);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
